// File: rtl/uart_pkg.sv
// Shared constants and helpers for the oversampling UART receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads as 0 while empty.
module sync_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 16
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [P_WIDTH-1:0]             wr_data,
    input  logic                           rd_en,
    output logic [P_WIDTH-1:0]             rd_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(P_DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(P_DEPTH);
    localparam int CNT_W = $clog2(P_DEPTH + 1);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(P_DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
    always_comb begin
        do_wr    = wr_en && (!full || rd_en);
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-voted bit recovery, optional parity, 1/2 stop bits,
// receive FIFO and sticky framing/parity/overrun flags.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int P_CLK_HZ     = 50_000_000,
    parameter int P_BAUD       = 9600,
    parameter int P_OVERSAMPLE = 16,
    parameter int P_DATA_BITS  = 8,
    parameter int P_PARITY     = 0,
    parameter int P_STOP_BITS  = 1,
    parameter int P_FIFO_DEPTH = 16
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic                                serial_in,
    input  logic                                rd_en,
    input  logic                                err_clear,
    output logic [P_DATA_BITS-1:0]              rd_data,
    output logic                                fifo_empty,
    output logic                                fifo_full,
    output logic [$clog2(P_FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                                frame_err,
    output logic                                parity_err,
    output logic                                overrun_err
);
    localparam int DIV    = uart_div(P_CLK_HZ, P_BAUD, P_OVERSAMPLE);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W   = $clog2(P_OVERSAMPLE);
    localparam int MID    = P_OVERSAMPLE / 2;
    localparam int BIT_W  = $clog2(P_DATA_BITS + 1);

    logic                   sync1_q, sync2_q;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [2:0]             state_q, state_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [P_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                   bad_q, bad_d;
    logic                   wr_q, wr_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_err_q, parity_err_d;
    logic                   overrun_err_q, overrun_err_d;
    logic                   tick, decide, bit_val, exp_par, new_frame, new_par, new_ovr;

    always_comb begin
        tick       = (tick_cnt_q == TICK_W'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        os_cnt_d = os_cnt_q;
        samp_d   = samp_q;
        if (tick) begin
            os_cnt_d = (os_cnt_q == OS_W'(P_OVERSAMPLE - 1)) ? '0 : os_cnt_q + 1'b1;
            if (os_cnt_q == OS_W'(MID - 1)) samp_d[0] = sync2_q;
            if (os_cnt_q == OS_W'(MID))     samp_d[1] = sync2_q;
        end
        // Third sample is taken live on the decision tick itself.
        decide  = tick && (os_cnt_q == OS_W'(MID + 1));
        bit_val = maj3({sync2_q, samp_q});
        exp_par = (P_PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        bad_d      = bad_q;
        wr_d       = 1'b0;
        new_frame  = 1'b0;
        new_par    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    bad_d      = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (decide) state_d = bit_val ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shreg_d = {bit_val, shreg_q[P_DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_W'(P_DATA_BITS - 1)) begin
                        state_d = (P_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    if (bit_val != exp_par) begin
                        new_par = 1'b1;
                        bad_d   = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    if (!bit_val) begin
                        new_frame = 1'b1;
                        state_d   = ST_WAIT_IDLE;
                    end else if (stop_cnt_q == 1'(P_STOP_BITS - 1)) begin
                        wr_d    = !bad_q;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        new_ovr       = wr_q && fifo_full && !rd_en;
        frame_err_d   = (frame_err_q && !err_clear) || new_frame;
        parity_err_d  = (parity_err_q && !err_clear) || new_par;
        overrun_err_d = (overrun_err_q && !err_clear) || new_ovr;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            tick_cnt_q    <= '0;
            os_cnt_q      <= '0;
            samp_q        <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            stop_cnt_q    <= 1'b0;
            shreg_q       <= '0;
            bad_q         <= 1'b0;
            wr_q          <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            sync1_q       <= serial_in;
            sync2_q       <= sync1_q;
            tick_cnt_q    <= tick_cnt_d;
            os_cnt_q      <= os_cnt_d;
            samp_q        <= samp_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            stop_cnt_q    <= stop_cnt_d;
            shreg_q       <= shreg_d;
            bad_q         <= bad_d;
            wr_q          <= wr_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

    sync_fifo #(
        .P_WIDTH (P_DATA_BITS),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .wr_en   (wr_q),
        .wr_data (shreg_q),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 depth-4 instance and an 8E1 depth-16 instance, scoreboard on pops.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_a, ser_b, rd_en_a, rd_en_b, clr_a, clr_b;
    logic [7:0] rd_a, rd_b;
    logic       empty_a, full_a, ferr_a, perr_a, oerr_a;
    logic       empty_b, full_b, ferr_b, perr_b, oerr_b;
    logic [2:0] cnt_a;
    logic [4:0] cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    uart_rx_os #(
        .P_CLK_HZ(1_600_000), .P_BAUD(10_000), .P_OVERSAMPLE(16), .P_DATA_BITS(8),
        .P_PARITY(0), .P_STOP_BITS(1), .P_FIFO_DEPTH(4)
    ) dut_a (
        .CLK(clk), .reset(reset), .serial_in(ser_a), .rd_en(rd_en_a), .err_clear(clr_a),
        .rd_data(rd_a), .fifo_empty(empty_a), .fifo_full(full_a), .fifo_count(cnt_a),
        .frame_err(ferr_a), .parity_err(perr_a), .overrun_err(oerr_a)
    );

    uart_rx_os #(
        .P_CLK_HZ(1_600_000), .P_BAUD(10_000), .P_OVERSAMPLE(16), .P_DATA_BITS(8),
        .P_PARITY(2), .P_STOP_BITS(1), .P_FIFO_DEPTH(16)
    ) dut_b (
        .CLK(clk), .reset(reset), .serial_in(ser_b), .rd_en(rd_en_b), .err_clear(clr_b),
        .rd_data(rd_b), .fifo_empty(empty_b), .fifo_full(full_b), .fifo_count(cnt_b),
        .frame_err(ferr_b), .parity_err(perr_b), .overrun_err(oerr_b)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop presents the head, which must match the oldest expected char.
    always @(negedge clk) begin
        if (!reset && rd_en_a) begin
            if (!empty_a) begin
                if (q_a.size() == 0) cmp("pop_a_unexpected", {24'd0, rd_a}, 32'hFFFF_FFFF);
                else cmp("pop_a_data", {24'd0, rd_a}, {24'd0, q_a.pop_front()});
            end else if (q_a.size() != 0) begin
                cmp("pop_a_empty_but_expected", 32'd1, 32'd0);
                void'(q_a.pop_front());
            end
        end
        if (!reset && rd_en_b) begin
            if (!empty_b) begin
                if (q_b.size() == 0) cmp("pop_b_unexpected", {24'd0, rd_b}, 32'hFFFF_FFFF);
                else cmp("pop_b_data", {24'd0, rd_b}, {24'd0, q_b.pop_front()});
            end else if (q_b.size() != 0) begin
                cmp("pop_b_empty_but_expected", 32'd1, 32'd0);
                void'(q_b.pop_front());
            end
        end
    end

    task automatic drive(input int which, input logic v);
        if (which == 0) ser_a = v;
        else ser_b = v;
    endtask

    task automatic hold_bit(input int which, input logic v);
        drive(which, v);
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    // par: 0 none, 1 odd, 2 even. With stop_low the line is left low on return.
    task automatic send(input int which, input logic [7:0] d, input int par, input bit flip,
                        input bit stop_low);
        logic p;
        hold_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(which, d[i]);
        if (par != 0) begin
            p = (par == 2) ? ^d : ~(^d);
            hold_bit(which, p ^ flip);
        end
        hold_bit(which, !stop_low);
        if (!stop_low) repeat (20) @(posedge clk);
    endtask

    task automatic pop(input int which);
        @(posedge clk); #1;
        if (which == 0) rd_en_a = 1'b1;
        else rd_en_b = 1'b1;
        @(posedge clk); #1;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    task automatic clear_errs(input int which);
        @(posedge clk); #1;
        if (which == 0) clr_a = 1'b1;
        else clr_b = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        cmp({tag, "_empty"}, {31'd0, empty_a}, 32'd1);
        cmp({tag, "_full"},  {31'd0, full_a},  32'd0);
        cmp({tag, "_count"}, {29'd0, cnt_a},   32'd0);
        cmp({tag, "_rdata"}, {24'd0, rd_a},    32'd0);
        cmp({tag, "_ferr"},  {31'd0, ferr_a},  32'd0);
        cmp({tag, "_perr"},  {31'd0, perr_a},  32'd0);
        cmp({tag, "_oerr"},  {31'd0, oerr_a},  32'd0);
    endtask

    initial begin
        reset = 1'b1;
        ser_a = 1'b1; ser_b = 1'b1;
        rd_en_a = 1'b0; rd_en_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_reset_a("rst");
        cmp("rst_b_empty", {31'd0, empty_b}, 32'd1);
        cmp("rst_b_perr",  {31'd0, perr_b},  32'd0);
        reset = 1'b0;
        repeat (50) @(posedge clk);

        // 8E1: good parity then flipped parity
        send(1, 8'h07, 2, 1'b0, 1'b0); q_b.push_back(8'h07);
        send(1, 8'h07, 2, 1'b1, 1'b0);
        cmp("e1_count", {27'd0, cnt_b}, 32'd1);
        cmp("e1_perr",  {31'd0, perr_b}, 32'd1);
        cmp("e1_ferr",  {31'd0, ferr_b}, 32'd0);
        pop(1);
        cmp("e1_empty_after_pop", {31'd0, empty_b}, 32'd1);
        clear_errs(1);
        cmp("e1_perr_cleared", {31'd0, perr_b}, 32'd0);

        // 8N1: two characters
        send(0, 8'hA5, 0, 1'b0, 1'b0); q_a.push_back(8'hA5);
        send(0, 8'h3C, 0, 1'b0, 1'b0); q_a.push_back(8'h3C);
        cmp("n1_count", {29'd0, cnt_a}, 32'd2);
        cmp("n1_ferr",  {31'd0, ferr_a}, 32'd0);
        cmp("n1_perr",  {31'd0, perr_a}, 32'd0);
        cmp("n1_oerr",  {31'd0, oerr_a}, 32'd0);
        pop(0);
        pop(0);
        cmp("n1_empty", {31'd0, empty_a}, 32'd1);

        // Stop bit held low, line released later
        send(0, 8'h55, 0, 1'b0, 1'b1);
        repeat (3 * BIT_CLKS) @(posedge clk);
        cmp("fe_ferr",  {31'd0, ferr_a},  32'd1);
        cmp("fe_empty", {31'd0, empty_a}, 32'd1);
        drive(0, 1'b1);
        repeat (2 * BIT_CLKS) @(posedge clk);
        cmp("fe_count_after_release", {29'd0, cnt_a}, 32'd0);
        send(0, 8'h55, 0, 1'b0, 1'b0); q_a.push_back(8'h55);
        cmp("fe_next_count", {29'd0, cnt_a}, 32'd1);
        pop(0);
        clear_errs(0);
        cmp("fe_ferr_cleared", {31'd0, ferr_a}, 32'd0);

        // 40-clock glitch on idle line
        drive(0, 1'b0);
        repeat (40) @(posedge clk);
        drive(0, 1'b1);
        repeat (20 * BIT_CLKS) @(posedge clk);
        cmp("gl_count", {29'd0, cnt_a}, 32'd0);
        cmp("gl_ferr",  {31'd0, ferr_a}, 32'd0);
        cmp("gl_perr",  {31'd0, perr_a}, 32'd0);
        cmp("gl_oerr",  {31'd0, oerr_a}, 32'd0);

        // Overrun on depth-4 FIFO
        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i), 0, 1'b0, 1'b0);
            if (i <= 4) q_a.push_back(8'(i));
        end
        cmp("ov_full",  {31'd0, full_a}, 32'd1);
        cmp("ov_count", {29'd0, cnt_a},  32'd4);
        cmp("ov_oerr",  {31'd0, oerr_a}, 32'd1);
        cmp("ov_ferr",  {31'd0, ferr_a}, 32'd0);
        for (int i = 0; i < 4; i++) pop(0);
        cmp("ov_drained", {31'd0, empty_a}, 32'd1);

        // Reset mid-frame with an entry queued and overrun_err still set
        send(0, 8'h11, 0, 1'b0, 1'b0);
        cmp("rs_pre_count", {29'd0, cnt_a}, 32'd1);
        hold_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(0, (i >= 2));
        drive(0, 1'b1);
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_a("rs");
        repeat (2 * BIT_CLKS) @(posedge clk);
        send(0, 8'h9C, 0, 1'b0, 1'b0); q_a.push_back(8'h9C);
        cmp("rs_next_count", {29'd0, cnt_a}, 32'd1);
        cmp("rs_next_ferr",  {31'd0, ferr_a}, 32'd0);
        pop(0);
        repeat (5) @(posedge clk);

        cmp("sb_a_drained", q_a.size(), 32'd0);
        cmp("sb_b_drained", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
